// File: rtl/riscv_multicycle_ctrl_if.sv
// Interface between the multicycle controller and the RV32I datapath.
// It carries the instruction fields and ALU flag in, and the datapath control strobes out.
interface riscv_multicycle_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       RegWrite;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;
   logic       illegal;

   // The controller is the master: it consumes instruction fields and drives the strobes.
   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             RegWrite, ImmSrc, ALUControl, state, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             RegWrite, ImmSrc, ALUControl, state, illegal
   );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control: Moore main FSM with registered per-state controls,
// plus combinational ALU and immediate decoders.
module riscv_multicycle_ctrl #(
   parameter bit ILLEGAL_TRAP = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   riscv_multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } stateT;

   typedef struct packed {
      logic       adrSrc;
      logic       irWrite;
      logic       memWrite;
      logic       regWrite;
      logic       pcUpdate;
      logic       branch;
      logic       illegal;
      logic [1:0] resultSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
   } ctrlT;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   stateT      state;
   stateT      nextState;
   ctrlT       ctrl;
   logic [2:0] aluControl;
   logic [1:0] immSrc;

   // Control word for a given state; loaded together with the state so outputs come straight from flops.
   function automatic ctrlT decodeState(input stateT s);
      ctrlT d;
      d = '0;
      case (s)
         FETCH: begin
            d.irWrite   = 1'b1;
            d.aluSrcB   = 2'b10;
            d.resultSrc = 2'b10;
            d.pcUpdate  = 1'b1;
         end
         DECODE: begin
            d.aluSrcA = 2'b01;
            d.aluSrcB = 2'b01;
         end
         MEMADR: begin
            d.aluSrcA = 2'b10;
            d.aluSrcB = 2'b01;
         end
         MEMREAD: begin
            d.adrSrc = 1'b1;
         end
         MEMWB: begin
            d.resultSrc = 2'b01;
            d.regWrite  = 1'b1;
         end
         MEMWRITE: begin
            d.adrSrc   = 1'b1;
            d.memWrite = 1'b1;
         end
         EXECR: begin
            d.aluSrcA = 2'b10;
            d.aluOp   = 2'b10;
         end
         EXECI: begin
            d.aluSrcA = 2'b10;
            d.aluSrcB = 2'b01;
            d.aluOp   = 2'b10;
         end
         ALUWB: begin
            d.regWrite = 1'b1;
         end
         BEQ: begin
            d.aluSrcA = 2'b10;
            d.aluOp   = 2'b01;
            d.branch  = 1'b1;
         end
         JAL: begin
            d.aluSrcA  = 2'b01;
            d.aluSrcB  = 2'b10;
            d.pcUpdate = 1'b1;
         end
         TRAP: begin
            d.illegal = 1'b1;
         end
         default: d = '0;
      endcase
      return d;
   endfunction

   // Next-state selection; an unknown opcode in DECODE either retires as a NOP or parks in TRAP.
   always_comb begin
      nextState = FETCH;
      case (state)
         FETCH:   nextState = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nextState = MEMADR;
               OP_R:         nextState = EXECR;
               OP_I:         nextState = EXECI;
               OP_BEQ:       nextState = BEQ;
               OP_JAL:       nextState = JAL;
               default:      nextState = ILLEGAL_TRAP ? TRAP : FETCH;
            endcase
         end
         MEMADR:   nextState = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  nextState = MEMWB;
         EXECR, EXECI, JAL: nextState = ALUWB;
         MEMWB, MEMWRITE, ALUWB, BEQ: nextState = FETCH;
         TRAP:     nextState = TRAP;
         default:  nextState = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         ctrl  <= decodeState(FETCH);
      end else begin
         state <= nextState;
         ctrl  <= decodeState(nextState);
      end
   end

   // Subtract only for R-type sub; I-type funct7 bit 5 is part of the immediate.
   always_comb begin
      aluControl = 3'b000;
      case (ctrl.aluOp)
         2'b00: aluControl = 3'b000;
         2'b01: aluControl = 3'b001;
         2'b10: begin
            case (bus.funct3)
               3'b000:  aluControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default: aluControl = 3'b000;
      endcase
   end

   always_comb begin
      immSrc = 2'b00;
      case (bus.op)
         OP_LW, OP_I: immSrc = 2'b00;
         OP_SW:       immSrc = 2'b01;
         OP_BEQ:      immSrc = 2'b10;
         OP_JAL:      immSrc = 2'b11;
         default:     immSrc = 2'b00;
      endcase
   end

   assign bus.PCWrite    = ctrl.pcUpdate | (ctrl.branch & bus.zero);
   assign bus.AdrSrc     = ctrl.adrSrc;
   assign bus.MemWrite   = ctrl.memWrite;
   assign bus.IRWrite    = ctrl.irWrite;
   assign bus.ResultSrc  = ctrl.resultSrc;
   assign bus.ALUSrcA    = ctrl.aluSrcA;
   assign bus.ALUSrcB    = ctrl.aluSrcB;
   assign bus.RegWrite   = ctrl.regWrite;
   assign bus.ImmSrc     = immSrc;
   assign bus.ALUControl = aluControl;
   assign bus.state      = state;
   assign bus.illegal    = ctrl.illegal;

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Moore-style main FSM plus combinational ALU and immediate decoders for the multicycle RV32I datapath.
- Sequences one shared ALU and one unified instruction/data memory across several cycles per instruction.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Sits between the instruction register and datapath; replaces the single-cycle control unit when the core runs multicycle.

Parameters:
- ILLEGAL_TRAP, 0: 0 = unknown opcode in DECODE returns to FETCH (NOP); 1 = enters TRAP and holds until reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 (A)
- ALUSrcB  out  2  00 = rs2 (WriteData), 01 = ImmExt, 10 = constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- state  out  4  current state (debug)
- illegal  out  1  high while in TRAP

Behaviour:
- Reset (async, any cycle, including mid-instruction): state = FETCH immediately. Outputs then show FETCH values: IRWrite = 1, PCWrite = 1, ResultSrc = 10, ALUSrcB = 10, all others 0.
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11
- Transitions:
  - FETCH -> DECODE, always.
  - DECODE, by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> FETCH, or TRAP when ILLEGAL_TRAP = 1
  - MEMADR -> MEMREAD if op = 0000011, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECR, EXECI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
  - TRAP -> TRAP.
- Internal signals: PCUpdate, Branch, ALUOp. PCWrite = PCUpdate | (Branch & zero).
- Per-state outputs; any output not listed is 0:
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10, PCUpdate = 1
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target)
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00
  - MEMREAD: ResultSrc = 00, AdrSrc = 1
  - MEMWB: ResultSrc = 01, RegWrite = 1
  - MEMWRITE: ResultSrc = 00, AdrSrc = 1, MemWrite = 1
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10
  - ALUWB: ResultSrc = 00, RegWrite = 1
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1
  - TRAP: all enables 0, illegal = 1
- ALU decoder (combinational):
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other -> 000
- Immediate decoder (combinational, from op, valid every state):
  - 0000011, 0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; other -> 00.
- Latency in cycles, FETCH to next FETCH: lw 5; sw, R, I, jal 4; beq 3; illegal (no trap) 2.
- State register updates only on clk rising edge; no output depends on clk directly.
- zero affects only PCWrite, and only in BEQ.

Test Plan:
- reset high for 2 cycles, then release with op = 0000011 -> state sequence 0, 1, 2, 3, 4, 0. In MEMWB: RegWrite = 1, ResultSrc = 01. ALUControl = 000 in MEMADR.
- op = 0100011 -> states 0, 1, 2, 5, 0. MemWrite = 1 and AdrSrc = 1 only in state 5; ImmSrc = 01 throughout; RegWrite never 1.
- op = 0110011, funct3 = 000, funct7b5 = 1 -> EXECR with ALUControl = 001. Repeat with funct3 = 010 -> 101, funct3 = 110 -> 011. Check op = 0010011, funct3 = 000, funct7b5 = 1 -> EXECI with ALUControl = 000.
- op = 1100011 with zero = 1 -> BEQ: ALUControl = 001, PCWrite = 1, then FETCH. Repeat with zero = 0 -> PCWrite = 0 in BEQ.
- op = 1101111 -> states 0, 1, 10, 8, 0. PCWrite = 1 in JAL; ImmSrc = 11; RegWrite = 1 in ALUWB.
- op = 1111111: with ILLEGAL_TRAP = 0 -> DECODE returns to FETCH. With ILLEGAL_TRAP = 1 -> state 11, illegal = 1 and held. Assert reset asynchronously mid-MEMREAD -> state = 0 before next clk edge.
